// File: rtl/mcpu_ctrl.sv
// Multi-cycle CPU main controller: Moore FSM sequencing fetch, decode, memory and writeback.
// Optional feature: define MCPU_JAL_EN to decode jal (opcode 000011) into the JAL state.
//
// state | meaning
// ------+-----------------------------------------------
// IF  0 | fetch instruction, PC+4 (holds until mem_ready)
// ID  1 | decode, precompute branch target
// MA  2 | lw/sw effective address
// MR  3 | memory read (holds until mem_ready)
// MW  4 | memory write (holds until mem_ready)
// LWB 5 | load writeback to rt
// RX  6 | R-type execute
// RWB 7 | R-type writeback to rd
// BR  8 | beq compare, PC <- target if zero
// JP  9 | jump
// IX 10 | addi execute
// IWB11 | addi writeback to rt
// JAL12 | jump and link (MCPU_JAL_EN only)
module mcpu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_we,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [3:0] S_IF  = 4'd0;
    localparam logic [3:0] S_ID  = 4'd1;
    localparam logic [3:0] S_MA  = 4'd2;
    localparam logic [3:0] S_MR  = 4'd3;
    localparam logic [3:0] S_MW  = 4'd4;
    localparam logic [3:0] S_LWB = 4'd5;
    localparam logic [3:0] S_RX  = 4'd6;
    localparam logic [3:0] S_RWB = 4'd7;
    localparam logic [3:0] S_BR  = 4'd8;
    localparam logic [3:0] S_JP  = 4'd9;
    localparam logic [3:0] S_IX  = 4'd10;
    localparam logic [3:0] S_IWB = 4'd11;
    localparam logic [3:0] S_JAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // funct goes straight to the ALU control decoder; the FSM never looks at it.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = S_IF;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        iord     = 1'b0;
        reg_we   = 1'b0;
        regdst   = 2'd0;
        memtoreg = 2'd0;
        alusrca  = 1'b0;
        alusrcb  = 2'd0;
        aluop    = 2'd0;
        pcsrc    = 2'd0;
        illegal  = 1'b0;
        case (state_q)
`ifdef MCPU_JAL_EN
            S_IF: begin
`else
            S_IF, S_JAL: begin
`endif
                mem_rd  = 1'b1;
                alusrcb = 2'd1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                state_d = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                alusrcb = 2'd3;
                case (opcode)
                    OP_RTYPE:      state_d = S_RX;
                    OP_LW, OP_SW:  state_d = S_MA;
                    OP_BEQ:        state_d = S_BR;
                    OP_ADDI:       state_d = S_IX;
                    OP_J:          state_d = S_JP;
`ifdef MCPU_JAL_EN
                    OP_JAL:        state_d = S_JAL;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MA: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                state_d = (opcode == OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                mem_rd  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_LWB : S_MR;
            end
            S_MW: begin
                mem_wr  = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_IF : S_MW;
            end
            S_LWB: begin
                reg_we   = 1'b1;
                memtoreg = 2'd1;
            end
            S_RX: begin
                alusrca = 1'b1;
                aluop   = 2'd2;
                state_d = S_RWB;
            end
            S_RWB: begin
                reg_we = 1'b1;
                regdst = 2'd1;
            end
            S_BR: begin
                alusrca = 1'b1;
                aluop   = 2'd1;
                pcsrc   = 2'd1;
                pc_we   = zero;
            end
            S_JP: begin
                pcsrc = 2'd2;
                pc_we = 1'b1;
            end
            S_IX: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                state_d = S_IWB;
            end
            S_IWB: begin
                reg_we = 1'b1;
            end
`ifdef MCPU_JAL_EN
            S_JAL: begin
                reg_we   = 1'b1;
                regdst   = 2'd2;
                memtoreg = 2'd2;
                pcsrc    = 2'd2;
                pc_we    = 1'b1;
            end
`endif
            default: state_d = S_IF;
        endcase
    end

endmodule
